// File: rtl/mod_settings_loader.sv
// Settings reader for the controller BRAM: polls CTL_FLAG, bursts 0x21..0x30 into shadows,
// clears MOD_SET by read-modify-write and publishes the whole set with a single UPDATE strobe.
//
//  state | meaning
//  POLL  | addr 0x00, waits out read latency, then watches CTL_FLAG bit 0 every cycle
//  READ  | issues 0x21..0x30, one word per cycle
//  DRAIN | waits for the tail of the read burst to land in the shadows
//  CLEAR | re-reads CTL_FLAG, writes it back with MOD_SET cleared
//  DONE  | shadows now visible on the outputs, UPDATE high
module mod_settings_loader #(
  parameter int BRAM_RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  bram_addr,
  input  logic [15:0] bram_rd_data,
  output logic        bram_we,
  output logic [15:0] bram_wr_data,
  output logic        req_rd_segment,
  output logic [15:0] cycle0,
  output logic [15:0] cycle1,
  output logic [31:0] freq_div0,
  output logic [31:0] freq_div1,
  output logic [31:0] rep0,
  output logic [31:0] rep1,
  output logic [7:0]  transition_mode,
  output logic [63:0] transition_value,
  output logic        update,
  output logic        busy
);

  typedef enum logic [2:0] {
    POLL  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [2:0] TMR_LOAD = 3'(BRAM_RD_LATENCY - 1);

  state_t      state;
  state_t      next_state;
  logic [2:0]  tmr;
  logic        tmr_tc;
  logic [4:0]  rd_pipe [BRAM_RD_LATENCY];
  logic [15:0] shadow  [16];

  assign tmr_tc = (tmr == 3'd0);
  assign update = (state == DONE);
  assign busy   = (state != POLL);

  always_comb begin
    next_state   = state;
    bram_we      = 1'b0;
    bram_wr_data = 16'h0000;
    case (state)
      POLL:  if (tmr_tc && bram_rd_data[0]) next_state = READ;
      READ:  if (bram_addr == 8'h30) next_state = DRAIN;
      DRAIN: if (tmr_tc) next_state = CLEAR;
      CLEAR: begin
        if (tmr_tc) begin
          bram_we      = 1'b1;
          bram_wr_data = bram_rd_data & 16'hFFFE;
          next_state   = DONE;
        end
      end
      DONE:    next_state = POLL;
      default: next_state = POLL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= POLL;
      tmr       <= TMR_LOAD;
      bram_addr <= 8'h00;
    end else begin
      state <= next_state;
      if (next_state != state) tmr <= TMR_LOAD;
      else if (!tmr_tc)        tmr <= tmr - 3'd1;
      if (next_state == READ)
        bram_addr <= (state == READ) ? bram_addr + 8'd1 : 8'h21;
      else
        bram_addr <= 8'h00;
    end
  end

  // Each issued burst address travels with its shadow index until its data returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BRAM_RD_LATENCY; i++) rd_pipe[i] <= 5'd0;
    end else begin
      rd_pipe[0] <= {state == READ, bram_addr[3:0] - 4'd1};
      for (int i = 1; i < BRAM_RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) shadow[i] <= 16'h0000;
    end else if (rd_pipe[BRAM_RD_LATENCY-1][4]) begin
      shadow[rd_pipe[BRAM_RD_LATENCY-1][3:0]] <= bram_rd_data;
    end
  end

  // Outputs load on the CLEAR->DONE edge so they change in the same cycle UPDATE is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_rd_segment   <= 1'b0;
      cycle0           <= 16'd1;
      cycle1           <= 16'd1;
      freq_div0        <= 32'd10;
      freq_div1        <= 32'd10;
      rep0             <= 32'hFFFF_FFFF;
      rep1             <= 32'hFFFF_FFFF;
      transition_mode  <= 8'h00;
      transition_value <= 64'h0;
    end else if (state == CLEAR && tmr_tc) begin
      req_rd_segment   <= shadow[0][0];
      cycle0           <= shadow[1];
      freq_div0        <= {shadow[3], shadow[2]};
      cycle1           <= shadow[4];
      freq_div1        <= {shadow[6], shadow[5]};
      rep0             <= {shadow[8], shadow[7]};
      rep1             <= {shadow[10], shadow[9]};
      transition_mode  <= shadow[11][7:0];
      transition_value <= {shadow[15], shadow[14], shadow[13], shadow[12]};
    end
  end

endmodule

// File: tb/tb_mod_settings_loader.sv
// Bench for mod_settings_loader: three instances (read latency 1, 2, 4), each with its own BRAM
// model, driven by directed and random CPU-style writes and checked against a word-packing model.
module tb_mod_settings_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_n   = 3'b000;
  int          cyc     = 0;
  logic        cpu_req = 1'b0;
  int          cpu_i   = 0;
  logic [7:0]  cpu_a   = 8'h00;
  logic [15:0] cpu_d   = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  wire [7:0]  addr_w [3];
  wire [15:0] rdd_w  [3];
  wire        we_w   [3];
  wire [15:0] wd_w   [3];
  wire        seg_w  [3];
  wire [15:0] c0_w   [3];
  wire [15:0] c1_w   [3];
  wire [31:0] f0_w   [3];
  wire [31:0] f1_w   [3];
  wire [31:0] r0_w   [3];
  wire [31:0] r1_w   [3];
  wire [7:0]  tm_w   [3];
  wire [63:0] tv_w   [3];
  wire        upd_w  [3];
  wire        bsy_w  [3];
  wire [31:0] upd_cnt_w [3];
  wire [31:0] we_cnt_w  [3];
  wire [31:0] bad_w     [3];
  wire [15:0] last_wd_w [3];

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    logic [15:0]  mem [256] = '{default: 16'h0000};
    logic [15:0]  pipe [L];
    logic [31:0]  upd_cnt = 0;
    logic [31:0]  we_cnt  = 0;
    logic [31:0]  bad     = 0;
    logic [15:0]  last_wd = 16'h0000;
    int           last_t  = -100;
    logic [232:0] prev    = '0;
    logic         prev_rst = 1'b0;
    wire  [232:0] outv = {seg_w[g], c0_w[g], c1_w[g], f0_w[g], f1_w[g], r0_w[g], r1_w[g],
                          tm_w[g], tv_w[g]};

    mod_settings_loader #(.BRAM_RD_LATENCY(L)) dut (
      .clk(clk), .rst_n(rst_n[g]),
      .bram_addr(addr_w[g]), .bram_rd_data(rdd_w[g]), .bram_we(we_w[g]), .bram_wr_data(wd_w[g]),
      .req_rd_segment(seg_w[g]), .cycle0(c0_w[g]), .cycle1(c1_w[g]),
      .freq_div0(f0_w[g]), .freq_div1(f1_w[g]), .rep0(r0_w[g]), .rep1(r1_w[g]),
      .transition_mode(tm_w[g]), .transition_value(tv_w[g]),
      .update(upd_w[g]), .busy(bsy_w[g])
    );

    // Read-before-write BRAM with L cycles from address to data.
    always @(posedge clk) begin
      pipe[0] <= mem[addr_w[g]];
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
      if (cpu_req && cpu_i == g) mem[cpu_a] <= cpu_d;
      if (we_w[g]) mem[addr_w[g]] <= wd_w[g];
    end
    assign rdd_w[g] = pipe[L-1];

    // Continuous protocol watch: UPDATE spacing, write target, outputs moving without UPDATE.
    always @(negedge clk) begin
      if (upd_w[g]) begin
        upd_cnt <= upd_cnt + 1;
        if (cyc - last_t < 20) bad <= bad + 1;
        last_t <= cyc;
      end
      if (we_w[g]) begin
        we_cnt  <= we_cnt + 1;
        last_wd <= wd_w[g];
        if (addr_w[g] != 8'h00 || !bsy_w[g]) bad <= bad + 1;
      end
      if (rst_n[g] && prev_rst && !upd_w[g] && outv != prev) bad <= bad + 1;
      prev     <= outv;
      prev_rst <= rst_n[g];
    end

    assign upd_cnt_w[g] = upd_cnt;
    assign we_cnt_w[g]  = we_cnt;
    assign bad_w[g]     = bad;
    assign last_wd_w[g] = last_wd;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  logic [15:0] ref_w [16];
  logic [15:0] pub_w [16];
  bit          pub_dflt;

  function automatic int lat(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
  endfunction

  task automatic cpu_wr(input int i, input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    cpu_req = 1'b1; cpu_i = i; cpu_a = a; cpu_d = d;
    if (a >= 8'h21 && a <= 8'h30) ref_w[4'(a - 8'h21)] = d;
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  task automatic check_outs(input int i, input string tag);
    logic        es;
    logic [15:0] ec0, ec1;
    logic [31:0] ef0, ef1, er0, er1;
    logic [7:0]  etm;
    logic [63:0] etv;
    if (pub_dflt) begin
      es = 1'b0; ec0 = 16'd1; ec1 = 16'd1; ef0 = 32'd10; ef1 = 32'd10;
      er0 = 32'hFFFF_FFFF; er1 = 32'hFFFF_FFFF; etm = 8'h00; etv = 64'h0;
    end else begin
      es  = pub_w[0][0];
      ec0 = pub_w[1];
      ef0 = {pub_w[3], pub_w[2]};
      ec1 = pub_w[4];
      ef1 = {pub_w[6], pub_w[5]};
      er0 = {pub_w[8], pub_w[7]};
      er1 = {pub_w[10], pub_w[9]};
      etm = pub_w[11][7:0];
      etv = {pub_w[15], pub_w[14], pub_w[13], pub_w[12]};
    end
    chk({tag, ".req_rd_segment"}, seg_w[i], es);
    chk({tag, ".cycle0"}, c0_w[i], ec0);
    chk({tag, ".cycle1"}, c1_w[i], ec1);
    chk({tag, ".freq_div0"}, f0_w[i], ef0);
    chk({tag, ".freq_div1"}, f1_w[i], ef1);
    chk({tag, ".rep0"}, r0_w[i], er0);
    chk({tag, ".rep1"}, r1_w[i], er1);
    chk({tag, ".transition_mode"}, tm_w[i], etm);
    chk({tag, ".transition_value"}, tv_w[i], etv);
  endtask

  // One complete load: optionally set the flag, wait for UPDATE, compare everything.
  task automatic load(input int i, input logic [15:0] flag, input bit wr, input bit do_lat,
                      input string tag);
    logic [31:0] u0, w0;
    int t0, t1;
    logic b;
    u0 = upd_cnt_w[i]; w0 = we_cnt_w[i]; t0 = -1; t1 = -1; b = 1'b0;
    if (wr) cpu_wr(i, 8'h00, flag);
    if (do_lat)
      for (int n = 0; n < 12 && t0 < 0; n++) begin
        @(negedge clk);
        if (rdd_w[i][0]) t0 = cyc;
      end
    for (int n = 0; n < 80 && t1 < 0; n++) begin
      @(negedge clk);
      if (upd_w[i]) begin t1 = cyc; b = bsy_w[i]; end
    end
    chk({tag, ".update_seen"}, 64'(t1 >= 0), 64'd1);
    if (do_lat) chk({tag, ".latency"}, 64'(t1 - t0), 64'(17 + 2 * lat(i)));
    chk({tag, ".busy_at_update"}, b, 1'b1);
    pub_w = ref_w; pub_dflt = 1'b0;
    check_outs(i, tag);
    @(negedge clk);
    chk({tag, ".update_count"}, upd_cnt_w[i] - u0, 32'd1);
    chk({tag, ".write_count"}, we_cnt_w[i] - w0, 32'd1);
    chk({tag, ".write_data"}, last_wd_w[i], flag & 16'hFFFE);
  endtask

  task automatic run_inst(input int i);
    int nz;
    logic [31:0] u0, w0;
    logic [15:0] flag;
    int wait_n;
    for (int k = 0; k < 16; k++) ref_w[k] = 16'h0000;
    pub_dflt = 1'b1;

    nz = 0;
    repeat (100) begin
      @(negedge clk);
      if (addr_w[i] != 8'h00 || we_w[i] || upd_w[i] || bsy_w[i]) nz++;
    end
    chk("idle.activity", 64'(nz), 64'd0);
    chk("idle.update_count", upd_cnt_w[i], 32'd0);
    check_outs(i, "idle");

    cpu_wr(i, 8'h21, 16'h0001); cpu_wr(i, 8'h22, 16'h0FFF); cpu_wr(i, 8'h23, 16'h5000);
    cpu_wr(i, 8'h24, 16'h0001); cpu_wr(i, 8'h28, 16'h0003); cpu_wr(i, 8'h2C, 16'h0001);
    cpu_wr(i, 8'h2D, 16'h0001); cpu_wr(i, 8'h2E, 16'h0002); cpu_wr(i, 8'h2F, 16'h0003);
    cpu_wr(i, 8'h30, 16'h0004);
    load(i, 16'h0001, 1'b1, 1'b1, "basic");
    chk("basic.freq_div0_lit", f0_w[i], 32'h0001_5000);
    chk("basic.transition_value_lit", tv_w[i], 64'h0004_0003_0002_0001);

    load(i, 16'h2021, 1'b1, 1'b1, "flag2021");

    u0 = upd_cnt_w[i]; w0 = we_cnt_w[i];
    cpu_wr(i, 8'h00, 16'h0004);
    repeat (60) @(negedge clk);
    chk("flag0004.update_count", upd_cnt_w[i] - u0, 32'd0);
    chk("flag0004.write_count", we_cnt_w[i] - w0, 32'd0);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 16; k++)
        if ($urandom_range(1, 0) == 1) cpu_wr(i, 8'(8'h21 + k), 16'($urandom));
      if (r == 0) cpu_wr(i, 8'h22, 16'h0000);
      flag = 16'($urandom) | 16'h0001;
      load(i, flag, 1'b1, 1'b1, "rand");
    end

    repeat (2) @(negedge clk);
    cpu_wr(i, 8'h25, 16'h0100);
    load(i, 16'h0001, 1'b1, 1'b1, "rearm");
    chk("rearm.cycle1_lit", c1_w[i], 16'h0100);

    u0 = upd_cnt_w[i]; w0 = we_cnt_w[i];
    cpu_wr(i, 8'h00, 16'h0001);
    wait_n = 0;
    while (addr_w[i] != 8'h29 && wait_n < 40) begin @(negedge clk); wait_n++; end
    chk("rst.reached_word8", 64'(wait_n < 40), 64'd1);
    rst_n[i] = 1'b0;
    #1;
    pub_dflt = 1'b1;
    check_outs(i, "rst");
    chk("rst.addr", addr_w[i], 8'h00);
    chk("rst.we", we_w[i], 1'b0);
    chk("rst.busy", bsy_w[i], 1'b0);
    chk("rst.update", upd_w[i], 1'b0);
    repeat (3) @(negedge clk);
    chk("rst.no_update", upd_cnt_w[i] - u0, 32'd0);
    chk("rst.no_write", we_cnt_w[i] - w0, 32'd0);
    rst_n[i] = 1'b1;
    load(i, 16'h0001, 1'b0, 1'b0, "rst_reload");

    chk("monitor.protocol", bad_w[i], 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 3'b111;
    for (int i = 0; i < 3; i++) run_inst(i);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
